// File: rtl/prog_mem_pkg.sv
// Shared types and default geometry for the program memory and the CPU core.
package prog_mem_pkg;

    // Programming controller states.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2
    } prog_state_t;

    // Default address / instruction widths, shared with the CPU.
    localparam int PM_AW = 1;
    localparam int PM_DW = 1;

    // Counter width able to index n positions (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prog_mem_if.sv
// CPU fetch port plus serial programming port of the program memory.
interface prog_mem_if
    import prog_mem_pkg::*;
#(
    parameter int AW = PM_AW,
    parameter int DW = PM_DW
) ();

    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          prog_en;
    logic          ser_valid;
    logic          ser_bit;
    logic          cpu_n_reset;
    logic          prog_busy;
    logic [AW:0]   word_count;
    logic          overflow;

    // Host / CPU side: drives address and programming stream.
    modport master (
        output addr, prog_en, ser_valid, ser_bit,
        input  data, cpu_n_reset, prog_busy, word_count, overflow
    );

    // Memory side.
    modport slave (
        input  addr, prog_en, ser_valid, ser_bit,
        output data, cpu_n_reset, prog_busy, word_count, overflow
    );

endinterface

// File: rtl/prog_mem_ser_deser.sv
// Serial-to-parallel converter: collects DW bits MSB first and flags the
// completed word combinationally on the strobe that delivers its last bit,
// so the caller can write it on that same clock edge.
module ser_deser
    import prog_mem_pkg::*;
#(
    parameter int DW = PM_DW
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          clear,
    input  logic          ser_valid,
    input  logic          ser_bit,
    output logic [DW-1:0] word,
    output logic          word_valid
);

    localparam int            CW   = cnt_width(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    logic [CW-1:0] bitcnt_reg;

    // The final bit of a word completes it; the pulse lasts one cycle.
    assign word_valid = ser_valid && (bitcnt_reg == LAST);

    // Bit counter; clear wins over the increment so a partial word is dropped.
    always_ff @(posedge clk) begin
        if (!n_reset || clear) begin
            bitcnt_reg <= '0;
        end else if (ser_valid) begin
            bitcnt_reg <= (bitcnt_reg == LAST) ? '0 : bitcnt_reg + 1'b1;
        end
    end

    // Only the first DW-1 bits need storage; the last one arrives with the strobe.
    generate
        if (DW == 1) begin : g_single
            assign word = ser_bit;
        end else begin : g_multi
            logic [DW-2:0] shift_reg;

            assign word = {shift_reg, ser_bit};

            // Shift in MSB first.
            always_ff @(posedge clk) begin
                if (!n_reset) begin
                    shift_reg <= '0;
                end else if (ser_valid) begin
                    shift_reg <= word[DW-2:0];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/prog_mem.sv
// Program memory with combinational fetch port and a serial programming
// port. While a program is shifted in, the CPU is held in reset; one extra
// RELEASE cycle guarantees a reset edge after the last write.
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int AW = PM_AW,
    parameter int DW = PM_DW
) (
    input  logic    clk,
    input  logic    n_reset,
    prog_mem_if.slave bus
);

    localparam int          DEPTH     = 2 ** AW;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_MAX   = '1;

    // Memory contents survive n_reset; they start out as all-zero (NOP).
    logic [DW-1:0] mem_reg [DEPTH] = '{default: '0};

    prog_state_t   state_reg, state_next;
    logic          start_load, end_load;
    logic          cpu_run, busy;
    logic [AW-1:0] waddr_reg;
    logic [AW:0]   word_count_reg;
    logic          overflow_reg;
    logic [DW-1:0] word;
    logic          word_valid;
    logic          sd_valid;

    // Serial strobes only count while loading.
    assign sd_valid = bus.ser_valid && (state_reg == LOAD);

    ser_deser #(.DW(DW)) u_ser_deser (
        .clk        (clk),
        .n_reset    (n_reset),
        .clear      (start_load || end_load),
        .ser_valid  (sd_valid),
        .ser_bit    (bus.ser_bit),
        .word       (word),
        .word_valid (word_valid)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state; CPU reset and busy depend on the registered state only.
    always_comb begin
        state_next = state_reg;
        start_load = 1'b0;
        end_load   = 1'b0;
        cpu_run    = 1'b1;
        busy       = 1'b0;
        case (state_reg)
            RUN: begin
                if (bus.prog_en) begin
                    state_next = LOAD;
                    start_load = 1'b1;
                end
            end
            LOAD: begin
                cpu_run = 1'b0;
                busy    = 1'b1;
                if (!bus.prog_en) begin
                    state_next = RELEASE;
                    end_load   = 1'b1;
                end
            end
            RELEASE: begin
                cpu_run    = 1'b0;
                busy       = 1'b1;
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Session bookkeeping: write address, saturating word count, sticky overflow.
    always_ff @(posedge clk) begin
        if (!n_reset || start_load) begin
            waddr_reg      <= '0;
            word_count_reg <= '0;
            overflow_reg   <= 1'b0;
        end else if (word_valid) begin
            waddr_reg <= waddr_reg + 1'b1;
            if (word_count_reg != CNT_MAX) begin
                word_count_reg <= word_count_reg + 1'b1;
            end
            if (word_count_reg >= DEPTH_CNT) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Memory write of each completed word; a reset edge aborts the write.
    always_ff @(posedge clk) begin
        if (n_reset && word_valid) begin
            mem_reg[waddr_reg] <= word;
        end
    end

    assign bus.data        = mem_reg[bus.addr];
    assign bus.cpu_n_reset = cpu_run;
    assign bus.prog_busy   = busy;
    assign bus.word_count  = word_count_reg;
    assign bus.overflow    = overflow_reg;

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: two instances (AW=1/DW=1 and AW=2/DW=4).
// Memory read-back expectations go through a scoreboard queue: pushed when
// the words are shifted in, popped when the memory is read after the session.
module tb_prog_mem;
    import prog_mem_pkg::*;

    logic clk = 1'b0;
    logic n_reset = 1'b0;

    always #5 clk = ~clk;

    prog_mem_if #(.AW(1), .DW(1)) bus_a ();
    prog_mem_if #(.AW(2), .DW(4)) bus_b ();

    prog_mem #(.AW(1), .DW(1)) dut_a (.clk(clk), .n_reset(n_reset), .bus(bus_a));
    prog_mem #(.AW(2), .DW(4)) dut_b (.clk(clk), .n_reset(n_reset), .bus(bus_b));

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty observed=%0h expected=none", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic send_a(input logic b);
        bus_a.ser_valid = 1'b1;
        bus_a.ser_bit   = b;
        tick();
        bus_a.ser_valid = 1'b0;
    endtask

    task automatic send_b(input logic b);
        bus_b.ser_valid = 1'b1;
        bus_b.ser_bit   = b;
        tick();
        bus_b.ser_valid = 1'b0;
    endtask

    task automatic send_b_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) begin
            send_b(w[i]);
        end
    endtask

    task automatic read_a(input int a);
        bus_a.addr = 1'(a);
        tick();
        sb_check(32'(bus_a.data));
    endtask

    task automatic read_b(input int a);
        bus_b.addr = 2'(a);
        tick();
        sb_check(32'(bus_b.data));
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_a.addr = '0; bus_a.prog_en = 1'b0; bus_a.ser_valid = 1'b0; bus_a.ser_bit = 1'b0;
        bus_b.addr = '0; bus_b.prog_en = 1'b0; bus_b.ser_valid = 1'b0; bus_b.ser_bit = 1'b0;

        // 1. Reset state and power-up contents
        tick();
        tick();
        chk("t1_a_cpu_n_reset", 32'(bus_a.cpu_n_reset), 1);
        chk("t1_a_prog_busy",   32'(bus_a.prog_busy),   0);
        chk("t1_a_word_count",  32'(bus_a.word_count),  0);
        chk("t1_a_overflow",    32'(bus_a.overflow),    0);
        chk("t1_b_cpu_n_reset", 32'(bus_b.cpu_n_reset), 1);
        n_reset = 1'b1;
        sb_push("t1_a_mem0", 0);
        sb_push("t1_a_mem1", 0);
        read_a(0);
        read_a(1);

        // 2. Basic load of 1,1 into the 2x1 memory
        sb_push("t2_a_mem0", 1);
        sb_push("t2_a_mem1", 1);
        bus_a.prog_en = 1'b1;
        #1;
        chk("t2_nrst_before_edge", 32'(bus_a.cpu_n_reset), 1);
        tick();
        chk("t2_nrst_load", 32'(bus_a.cpu_n_reset), 0);
        chk("t2_busy_load", 32'(bus_a.prog_busy),   1);
        bus_a.addr = 1'b0;
        send_a(1'b1);
        chk("t2_read_after_write", 32'(bus_a.data),       1);
        chk("t2_wc_one",           32'(bus_a.word_count), 1);
        send_a(1'b1);
        bus_a.prog_en = 1'b0;
        #1;
        chk("t2_nrst_fall_0", 32'(bus_a.cpu_n_reset), 0);
        tick();
        chk("t2_nrst_release", 32'(bus_a.cpu_n_reset), 0);
        chk("t2_busy_release", 32'(bus_a.prog_busy),   1);
        tick();
        chk("t2_nrst_run",  32'(bus_a.cpu_n_reset), 1);
        chk("t2_busy_run",  32'(bus_a.prog_busy),   0);
        chk("t2_wc",        32'(bus_a.word_count),  2);
        chk("t2_overflow",  32'(bus_a.overflow),    0);
        read_a(0);
        read_a(1);

        // 3. Multi-bit words: 4'b1010 then 4'b0011, last bit with prog_en falling
        sb_push("t3_b_mem0", 32'hA);
        sb_push("t3_b_mem1", 32'h3);
        sb_push("t3_b_mem2", 32'h0);
        sb_push("t3_b_mem3", 32'h0);
        bus_b.prog_en = 1'b1;
        tick();
        chk("t3_busy_load", 32'(bus_b.prog_busy), 1);
        send_b_word(4'b1010);
        send_b(1'b0);
        send_b(1'b0);
        send_b(1'b1);
        bus_b.prog_en   = 1'b0;
        bus_b.ser_valid = 1'b1;
        bus_b.ser_bit   = 1'b1;
        tick();
        bus_b.ser_valid = 1'b0;
        chk("t3_nrst_release", 32'(bus_b.cpu_n_reset), 0);
        tick();
        chk("t3_nrst_run", 32'(bus_b.cpu_n_reset), 1);
        chk("t3_wc",       32'(bus_b.word_count),  2);
        chk("t3_overflow", 32'(bus_b.overflow),    0);
        for (int i = 0; i < 4; i++) read_b(i);

        // 4. Partial word discarded: 1,0,1,0,1,1
        sb_push("t4_b_mem0", 32'hA);
        sb_push("t4_b_mem1", 32'h3);
        bus_b.prog_en = 1'b1;
        tick();
        send_b_word(4'b1010);
        send_b(1'b1);
        send_b(1'b1);
        bus_b.prog_en = 1'b0;
        tick();
        tick();
        chk("t4_wc",   32'(bus_b.word_count),  1);
        chk("t4_nrst", 32'(bus_b.cpu_n_reset), 1);
        read_b(0);
        read_b(1);

        // 4b. Next session restarts at bit 0 / address 0
        sb_push("t4b_b_mem0", 32'h5);
        sb_push("t4b_b_mem1", 32'h3);
        bus_b.prog_en = 1'b1;
        tick();
        chk("t4b_wc_cleared", 32'(bus_b.word_count), 0);
        send_b_word(4'b0101);
        bus_b.prog_en = 1'b0;
        tick();
        tick();
        chk("t4b_wc", 32'(bus_b.word_count), 1);
        read_b(0);
        read_b(1);

        // 5. Overflow: 1,0,1 into the 2x1 memory, then one more for saturation
        sb_push("t5_a_mem0", 1);
        sb_push("t5_a_mem1", 0);
        bus_a.prog_en = 1'b1;
        tick();
        chk("t5_wc_cleared", 32'(bus_a.word_count), 0);
        send_a(1'b1);
        send_a(1'b0);
        chk("t5_no_ovf_at_depth", 32'(bus_a.overflow), 0);
        send_a(1'b1);
        chk("t5_ovf_set", 32'(bus_a.overflow),   1);
        chk("t5_wc_3",    32'(bus_a.word_count), 3);
        send_a(1'b0);
        chk("t5_wc_saturated", 32'(bus_a.word_count), 3);
        bus_a.prog_en = 1'b0;
        tick();
        tick();
        chk("t5_ovf_sticky", 32'(bus_a.overflow),   1);
        chk("t5_wc_run",     32'(bus_a.word_count), 3);
        read_a(0);
        read_a(1);

        // 6. Reset in the middle of a load session
        bus_a.prog_en = 1'b1;
        tick();
        chk("t6_ovf_cleared", 32'(bus_a.overflow),    0);
        chk("t6_wc_cleared",  32'(bus_a.word_count),  0);
        chk("t6_nrst_load",   32'(bus_a.cpu_n_reset), 0);
        send_a(1'b1);
        chk("t6_wc_one", 32'(bus_a.word_count), 1);
        n_reset       = 1'b0;
        bus_a.prog_en = 1'b0;
        tick();
        n_reset = 1'b1;
        chk("t6_nrst_after_rst", 32'(bus_a.cpu_n_reset), 1);
        chk("t6_busy_after_rst", 32'(bus_a.prog_busy),   0);
        chk("t6_wc_after_rst",   32'(bus_a.word_count),  0);
        send_a(1'b0);
        send_a(1'b0);
        chk("t6_wc_run_ignored",   32'(bus_a.word_count), 0);
        chk("t6_busy_run_ignored", 32'(bus_a.prog_busy),  0);
        sb_push("t6_a_mem0", 1);
        sb_push("t6_a_mem1", 0);
        read_a(0);
        read_a(1);

        chk("sb_drained", 32'(sb_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
